decoder: RTL and testbench



---
 rtl/decoder_pkg.sv | 13 +
 rtl/decoder_if.sv | 14 +
 rtl/decoder_comb.sv | 20 ++
 rtl/decoder.sv | 49 ++++
 tb/tb_decoder.sv | 110 +++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decode constants and one-hot mapping
package decoder_pkg;

    localparam int COND_SEL_W  = 2;
    localparam int DEC_MAX_W   = 6;
    localparam int DEC_MAX_OUT = 2 ** DEC_MAX_W;

    // Fixed maximum width; callers zero-extend the select and truncate the result.
    function automatic logic [DEC_MAX_OUT-1:0] onehot_decode(input logic [DEC_MAX_W-1:0] v);
        return DEC_MAX_OUT'(1) << v;
    endfunction

endpackage

// File: rtl/decoder_if.sv
// rtl/decoder_if.sv - select/enable inputs and decoded outputs bundle
interface decoder_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 2 ** IN_W
);
    logic [IN_W-1:0]  in;
    logic             en;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] out_q;
    logic             out_q_valid;

    modport master (output in, output en, input out, input out_q, input out_q_valid);
    modport slave  (input in, input en, output out, output out_q, output out_q_valid);
endinterface

// File: rtl/decoder_comb.sv
// rtl/decoder_comb.sv - pure combinational binary-to-one-hot decode with enable gate
module decoder_comb
    import decoder_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 2 ** IN_W
) (
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_W-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out = OUT_W'(onehot_decode(DEC_MAX_W'(in)));
        end
    end

endmodule

// File: rtl/decoder.sv
// rtl/decoder.sv - one-hot decoder with combinational output and registered copy
module decoder
    import decoder_pkg::*;
#(
    parameter int IN_W  = COND_SEL_W,
    parameter int OUT_W = 2 ** IN_W
) (
    input  logic     clk,
    input  logic     rst_n,
    decoder_if.slave bus
);

    logic [OUT_W-1:0] dec;

    decoder_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .in  (bus.in),
        .en  (bus.en),
        .out (dec)
    );

    assign bus.out = dec;

    // Registered copy reuses the gated decode; en=0 holds the last capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_q       <= '0;
            bus.out_q_valid <= 1'b0;
        end else if (bus.en) begin
            bus.out_q       <= dec;
            bus.out_q_valid <= 1'b1;
        end else begin
            bus.out_q_valid <= 1'b0;
        end
    end

`ifdef SIMULATION
    if (IN_W < 1 || IN_W > DEC_MAX_W || OUT_W != 2 ** IN_W) begin : g_param_check
        $error("decoder: illegal IN_W/OUT_W combination");
    end

    a_onehot0 : assert property (@(posedge clk) $onehot0(bus.out));
    a_onehot  : assert property (@(posedge clk) bus.en |-> $onehot(bus.out));
    a_in_known: assert property (@(posedge clk) bus.en |-> !$isunknown(bus.in));
`endif

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - scoreboard bench for decoder with parameter sweep instances
module tb_decoder;

    typedef struct packed {
        logic [3:0] q;
        logic       v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    decoder_if #(.IN_W(2)) bus ();
    decoder_if #(.IN_W(1)) bus1 ();
    decoder_if #(.IN_W(3)) bus3 ();
    decoder_if #(.IN_W(4)) bus4 ();

    decoder #(.IN_W(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    decoder #(.IN_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    decoder #(.IN_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    decoder #(.IN_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: compares registered outputs one edge after each issued vector.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_q", 16'(bus.out_q), 16'(e.q));
            check("out_q_valid", 16'(bus.out_q_valid), 16'(e.v));
        end else if (bus.out_q_valid === 1'b1) begin
            check("unexpected_valid", 16'(bus.out_q_valid), 16'd0);
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] i,
                        input logic [3:0] exp_out, input logic [3:0] exp_q, input logic exp_v);
        @(negedge clk);
        rst_n  = r;
        bus.en = e;
        bus.in = i;
        #1;
        check("out", 16'(bus.out), 16'(exp_out));
        sb.push_back('{q: exp_q, v: exp_v});
    endtask

    initial begin
        bus.en = 1'b0; bus.in = '0;
        bus1.en = 1'b0; bus1.in = '0;
        bus3.en = 1'b0; bus3.in = '0;
        bus4.en = 1'b0; bus4.in = '0;

        step(1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1);
        step(1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1);
        check("cond_sel_not_flag", 16'({bus.out[2], bus.out[1:0]}), 16'b100);
        step(1'b1, 1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1);
        step(1'b1, 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b1);
        step(1'b1, 1'b0, 2'd3, 4'b0000, 4'b0010, 1'b0);
        step(1'b1, 1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1);
        step(1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0100, 1'b0);

        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus1.en = 1'b1; bus1.in = 1'(i); #1;
            check("sweep_w1", 16'(bus1.out), 16'(1) << i);
        end
        for (int i = 0; i < 8; i++) begin
            bus3.en = 1'b1; bus3.in = 3'(i); #1;
            check("sweep_w3", 16'(bus3.out), 16'(1) << i);
        end
        for (int i = 0; i < 16; i++) begin
            bus4.en = 1'b1; bus4.in = 4'(i); #1;
            check("sweep_w4", 16'(bus4.out), 16'(1) << i);
        end
        bus3.in = 3'd5; #1;
        check("sweep_w3_in5", 16'(bus3.out), 16'b0010_0000);
        bus1.en = 1'b0; bus3.en = 1'b0; bus4.en = 1'b0;

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending expected responses, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
